// File: rtl/normalizer.sv
// Iterative leading-bit normalizer: shifts left one bit per cycle until the word is
// normalized, reporting the shift count so that a right shift of the result recovers the input.
module normalizer #(
  parameter int DATA_WDTH = 32,
  parameter int SV_WDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WDTH-1:0] data,
  input  logic                 opr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WDTH-1:0] out_data,
  output logic [SV_WDTH-1:0]   sv,
  output logic                 zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WDTH-1:0] word;
    logic [SV_WDTH-1:0]   cnt;
    logic                 zero;
  } res_t;

  state_t               state, state_nxt;
  logic [DATA_WDTH-1:0] work, work_nxt;
  logic [SV_WDTH-1:0]   cnt, cnt_nxt;
  logic                 sgn, sgn_nxt;
  res_t                 res, res_nxt;
  logic                 accept, insig, normed;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // All-zeros (or all-ones when signed) has no significant bit; catching it here bounds the loop.
  assign insig  = (data == '0) | (opr & (data == '1));
  assign normed = sgn ? (work[DATA_WDTH-1] ^ work[DATA_WDTH-2]) : work[DATA_WDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      sgn   <= sgn_nxt;
      res   <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    sgn_nxt   = sgn;
    res_nxt   = res;
    unique case (state)
      IDLE: begin
        if (accept) begin
          work_nxt = data;
          sgn_nxt  = opr;
          cnt_nxt  = '0;
          if (insig) begin
            state_nxt    = DONE;
            res_nxt.word = data;
            res_nxt.cnt  = '0;
            res_nxt.zero = 1'b1;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (normed) begin
          state_nxt    = DONE;
          res_nxt.word = work;
          res_nxt.cnt  = cnt;
          res_nxt.zero = 1'b0;
        end else begin
          work_nxt = {work[DATA_WDTH-2:0], 1'b0};
          cnt_nxt  = cnt + SV_WDTH'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign out_data  = res.word;
  assign sv        = res.cnt;
  assign zero      = res.zero;

  // Signed words never need more than DATA_WDTH-2 shifts; the pre-check guarantees this.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT) |-> (sgn ? (int'(cnt) <= DATA_WDTH-2) : (int'(cnt) <= DATA_WDTH-1)));

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: driver pushes reference results at accept, monitor
// pops and compares on each output handshake, including latency and the inverse-shift identity.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data = '0;
  logic        opr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  sv;
  logic        zero;

  normalizer #(.DATA_WDTH(32), .SV_WDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .opr(opr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sv(sv), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          o;
    logic [31:0] q;
    int          k;
    bit          z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   pulse_cyc = -1;
  bit   busy = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shift count = leading zeros (unsigned) or redundant sign bits (signed).
  function automatic int ref_k(logic [31:0] d, bit o);
    for (int i = 31; i >= 0; i--) begin
      if (o) begin
        if (i < 31 && d[i] != d[31]) return 30 - i;
      end else if (d[i]) begin
        return 31 - i;
      end
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic send(logic [31:0] d, bit o);
    exp_t e;
    int   n = 0;
    int   k;
    in_valid = 1'b1;
    data     = d;
    opr      = o;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      k     = ref_k(d, o);
      e.d   = d;
      e.o   = o;
      e.z   = (k < 0);
      e.k   = e.z ? 0 : k;
      e.q   = e.z ? d : (d << k);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    data     = $urandom;
    opr      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Consumer readiness: always, random stalls, or held low except a one-cycle pulse.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = (cyc == pulse_cyc);
    endcase
  end

  // Monitor: checks every cycle the output is valid against the scoreboard head.
  initial forever begin
    exp_t        e;
    logic [31:0] inv;
    @(negedge clk);
    if (rst) begin
      busy = 1'b0;
      seen = 1'b0;
    end else begin
      chk("no_x", 32'($isunknown({out_valid, out_data, sv, zero, in_ready})), 32'd0);
      chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("out_data", out_data, e.q);
          chk("sv", 32'(sv), 32'(e.k));
          chk("zero", 32'(zero), 32'(e.z));
          if (!seen) chk("latency", 32'(cyc - e.acc), 32'(e.z ? 1 : e.k + 2));
          seen = 1'b1;
          if (out_ready) begin
            if (!zero) begin
              inv = e.o ? 32'($signed(out_data) >>> sv) : (out_data >> sv);
              chk("inverse_shift", inv, e.d);
            end
            void'(sb.pop_front());
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) busy = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sv", 32'(sv), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    rdy_mode = 0;
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0001, 1'b0);
    send(32'h0001_2345, 1'b0);
    send(32'hFFFF_FFFE, 1'b1);
    send(32'h0000_0001, 1'b1);
    send(32'hC000_0000, 1'b1);
    send(32'h0000_0000, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0000, 1'b1);
    wait_idle();

    // Reset while the long unsigned shift is in progress.
    send(32'h0000_0001, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sv", 32'(sv), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(32'h8000_0000, 1'b0);
    wait_idle();

    // Backpressure: hold the result for 10 cycles, then a single ready pulse.
    rdy_mode = 2;
    send(32'h0001_2345, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
    end
    pulse_cyc = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    rdy_mode = 0;
    @(posedge clk); #1;

    rdy_mode = 1;
    repeat (1500) begin
      case ($urandom_range(0, 9))
        0:       d = 32'h0;
        1:       d = 32'hFFFF_FFFF;
        2:       d = $urandom >> $urandom_range(0, 31);
        3:       d = ~($urandom >> $urandom_range(0, 31));
        default: d = $urandom >> $urandom_range(0, 8);
      endcase
      send(d, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
